// File: rtl/instr_fetch_buffer_pkg.sv
// instr_fetch_buffer_pkg: default fetch geometry and the QUIT / slp-nop opcode bytes shared by fetch, decoder and benches
package instr_fetch_buffer_pkg;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic [7:0] QUIT = 8'h0E;
  localparam logic [7:0] NOP = 8'h00;
endpackage

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: ROM bus (rom_addr/rom_data), decoder handshake (instr/instr_pc/instr_valid/instr_ready) and control (fetch_en/redirect/redirect_addr); master = fetch stage, slave = ROM+decoder side
interface instr_fetch_buffer_if import instr_fetch_buffer_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
);
  logic fetch_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [WORD_WIDTH-1:0] rom_data;
  logic [WORD_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic instr_valid;
  logic instr_ready;
  logic redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  modport master (
    input fetch_en, rom_data, instr_ready, redirect, redirect_addr,
    output rom_addr, instr, instr_pc, instr_valid
  );
  modport slave (
    output fetch_en, rom_data, instr_ready, redirect, redirect_addr,
    input rom_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// fetch_fifo: {pc, instr} prefetch FIFO; ports clk, reset (async active-low), push/push_pc/push_data, pop, clear, head_pc/head_data (0 when empty), count, empty
module fetch_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [WORD_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [WORD_WIDTH-1:0] head_data,
  output logic [PW:0]           count,
  output logic                  empty
);
  logic [PW:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH+WORD_WIDTH-1:0] mem [DEPTH];
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign {head_pc, head_data} = empty ? '0 : mem[rd_ptr[PW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (PW+1)'(push);
      rd_ptr <= rd_ptr + (PW+1)'(pop && !empty);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr[PW-1:0]] <= {push_pc, push_data};
  assert property (@(posedge clk) disable iff (!reset) !(push && count[PW]));
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: ROM fetch stage with credit-limited prefetch FIFO; ports clk, reset (async active-low), bus (instr_fetch_buffer_if.master)
module instr_fetch_buffer import instr_fetch_buffer_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic reset,
  instr_fetch_buffer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_WIDTH-1:0] pc, inflight_pc;
  logic inflight, pop, issue, empty;
  logic [PW:0] count;
  logic [PW+1:0] occ_after_pop;
  assign pop = bus.instr_valid & bus.instr_ready;
  // the read in flight already owns a FIFO slot, so it counts against the credit
  assign occ_after_pop = {1'b0, count} + (PW+2)'(inflight) - (PW+2)'(pop);
  assign issue = bus.fetch_en & ~bus.redirect & (occ_after_pop < (PW+2)'(DEPTH));
  assign bus.rom_addr = pc;
  assign bus.instr_valid = ~empty;
  fetch_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight & ~bus.redirect),
    .pop       (pop & ~bus.redirect),
    .clear     (bus.redirect),
    .push_pc   (inflight_pc),
    .push_data (bus.rom_data),
    .head_pc   (bus.instr_pc),
    .head_data (bus.instr),
    .count     (count),
    .empty     (empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= '0;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      pc <= bus.redirect_addr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc <= pc + 1'b1;
      end
    end
endmodule
